fp_issue_ctrl: RTL and testbench
================================

# fp_issue_ctrl

Parametrised issue/writeback controller between the core's FP decode stage and `fpnew_top`. It allows up to `NUM_TAGS` FP operations in flight, blocks RAW/WAW hazards with a 32-entry FP-register scoreboard, and tags each operation. Returning results are buffered in a `RES_DEPTH`-entry FIFO and drained to the FP or integer register file through a valid/ready writeback port.

## Interface
- `NUM_TAGS`, 4: maximum outstanding operations; power of 2, ≥2; `TAG_W = $clog2(NUM_TAGS)`.
- `RES_DEPTH`, 2: result FIFO depth; ≥1.
- `clk_i`  in  1  clock. Single clock domain.
- `rst_ni`  in  1  asynchronous active-low reset.
- `issue_valid_i`  in  1  decoded FP op presented.
- `issue_ready_o`  out  1  op accepted this cycle when high together with `issue_valid_i`.
- `issue_rs_i`  in  15  `{rs3, rs2, rs1}` FP source register addresses.
- `issue_rs_used_i`  in  3  per-source read enable (bit 0 = rs1).
- `issue_rd_i`  in  5  destination register.
- `issue_wr_fp_i`  in  1  1 = destination is the FP register file; 0 = integer register file.
- `fpu_valid_o`  out  1  drive to `in_valid_i` of `fpnew_top`.
- `fpu_ready_i`  in  1  from `in_ready_o` of `fpnew_top`.
- `fpu_tag_o`  out  `TAG_W`  allocated tag.
- `fpu_out_valid_i`  in  1  result valid from the FPU.
- `fpu_out_ready_o`  out  1  result accepted from the FPU.
- `fpu_tag_i`  in  `TAG_W`  returning tag.
- `fpu_result_i`  in  32  result data.
- `fpu_status_i`  in  5  `{NV,DZ,OF,UF,NX}`.
- `wb_valid_o`  out  1  writeback entry available.
- `wb_ready_i`  in  1  writeback consumed.
- `wb_rd_o`  out  5  writeback destination.
- `wb_fp_o`  out  1  1 = FP register file, 0 = integer register file.
- `wb_data_o`  out  32  writeback data.
- `flush_i`  in  1  kill all in-flight state; also drives `fpnew_top.flush_i`.
- `busy_o`  out  1  any tag valid or FIFO non-empty.
- `fflags_o`  out  5  sticky accrued exception flags.
- `fflags_clr_i`  in  1  clear accrued flags.

## Operation
- **Tag table.** `NUM_TAGS` entries of `{valid, rd, wr_fp}`. Allocation takes the lowest-index free entry from the registered valid vector.
- **Scoreboard.** `sb[31:0]`, one bit per FP register, registered.
- **Hazard.** Asserted when any used `rs` has its `sb` bit set, or when `issue_wr_fp_i` and `sb[issue_rd_i]` are both set.
- **Free tag.** `tag_free` = at least one table entry invalid.
- **Issue.**
  - `fpu_valid_o = issue_valid_i & !hazard & tag_free & !flush_i`.
  - `issue_ready_o = fpu_valid_o & fpu_ready_i`.
  - On handshake: set the allocated entry's valid bit, store `rd`/`wr_fp`, and set `sb[rd]` if `wr_fp`.
- **Return.**
  - `fpu_out_ready_o = !fifo_full`.
  - When `fpu_out_valid_i & fpu_out_ready_o` and `table[fpu_tag_i].valid`: push `{rd, wr_fp, result}` and invalidate that entry.
  - When the entry is invalid: drop the result, with no push.
- **Writeback.** The FIFO head drives `wb_*`. On `wb_valid_o & wb_ready_i`: pop, and clear `sb[rd]` if `wr_fp`.
- **Flush.** One cycle; clears the table, the scoreboard, and the FIFO pointers. `fflags_o` is kept. Issue is blocked during the flush cycle.
- **Simultaneous events.**
  - Tag freed and allocated in the same cycle: the freed tag is not reusable until the next cycle.
  - `sb` bit cleared and a dependent op presented in the same cycle: the dependent op issues in the next cycle. There is no bypass.
  - Push and pop in the same cycle while full: the push is refused (`ready = !full`); the pop proceeds.
- **Reset.**
  - All table valid bits, `sb`, FIFO pointers, and `fflags_o` are 0.
  - `wb_valid_o` = 0, `busy_o` = 0, `fpu_out_ready_o` = 1.
  - `fpu_valid_o` and `issue_ready_o` are 0 while `rst_ni` is low.
  - Reset asserted mid-operation discards everything in flight.

## Timing
- Issue: 0-cycle combinational path from `issue_valid_i` to `fpu_valid_o`.
- Result: accepted in cycle N, `wb_valid_o` is high in cycle N+1.
- Scoreboard: cleared on writeback in cycle N; a dependent op can issue in cycle N+1.
- Flags: `fflags_o` updates the cycle after the result is accepted.
- Throughput: one issue and one writeback per cycle when there are no hazards.

## Configuration
- `FP_FLAGS_ACCUM_EN` defined: 5-bit sticky register.
  - `fflags <= (fflags_clr_i ? 0 : fflags) | accepted_status`.
  - Set and clear in the same cycle: the new flags survive.
- `FP_FLAGS_ACCUM_EN` undefined: no register; `fflags_o` is tied to 0 and `fflags_clr_i` is ignored.

## Test plan
- **Independent issue.** Issue 4 independent ops (`rd` = 1, 2, 3, 4) with `fpu_ready_i` = 1. Expect tags 0, 1, 2, 3. The 5th op stalls with `issue_ready_o` = 0 until a result returns.
- **RAW hazard.** Issue `fadd` with `rd` = 5, then an op with rs1 = 5. The second op stalls; it issues in the cycle after the writeback of `f5`.
- **Out-of-order return.** Return tags in order 2, 0, 1 with distinct data. Expect `wb_rd_o`/`wb_data_o` in return order and `busy_o` = 0 after the last pop.
- **FIFO backpressure.** With `RES_DEPTH` = 2 and `wb_ready_i` = 0, return 3 results. Expect `fpu_out_ready_o` = 0 on the 3rd; it is accepted after one pop.
- **Flush.** Assert `flush_i` with 3 ops in flight. Next cycle: `busy_o` = 0 and `sb` = 0. A stale result carrying tag 1 is dropped with no writeback.
- **Flag accumulation.** Return status `5'b00001`, then `5'b10000`. Expect `fflags_o` = `5'b10001`. Assert `fflags_clr_i` together with a result carrying status `5'b00100`: expect `fflags_o` = `5'b00100`. With the macro undefined, `fflags_o` stays 0.

Source files
------------

// File: rtl/fp_issue_ctrl.sv
// FP issue/writeback controller: tag table, FP scoreboard and result FIFO in front of fpnew_top.
// Optional FP_FLAGS_ACCUM_EN adds a sticky accrued-exception register on fflags_o.
module fp_issue_ctrl #(
  parameter int unsigned NUM_TAGS  = 4,
  parameter int unsigned RES_DEPTH = 2,
  localparam int unsigned TAG_W    = $clog2(NUM_TAGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [14:0]      issue_rs_i,
  input  logic [2:0]       issue_rs_used_i,
  input  logic [4:0]       issue_rd_i,
  input  logic             issue_wr_fp_i,
  output logic             fpu_valid_o,
  input  logic             fpu_ready_i,
  output logic [TAG_W-1:0] fpu_tag_o,
  input  logic             fpu_out_valid_i,
  output logic             fpu_out_ready_o,
  input  logic [TAG_W-1:0] fpu_tag_i,
  input  logic [31:0]      fpu_result_i,
  input  logic [4:0]       fpu_status_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [4:0]       wb_rd_o,
  output logic             wb_fp_o,
  output logic [31:0]      wb_data_o,
  input  logic             flush_i,
  output logic             busy_o,
  output logic [4:0]       fflags_o,
  input  logic             fflags_clr_i
);

  localparam int unsigned PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RES_DEPTH - 1);

  logic [NUM_TAGS-1:0] vld_q, vld_d;
  logic [NUM_TAGS-1:0] tfp_q, tfp_d;
  logic [4:0]          trd_q [NUM_TAGS];
  logic [4:0]          trd_d [NUM_TAGS];
  logic [31:0]         sb_q, sb_d;
  logic [37:0]         mem_q [RES_DEPTH];
  logic [37:0]         mem_d [RES_DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic [PTR_W-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic             hazard, tag_free, fifo_full, fifo_empty;
  logic             issue_fire, push, pop;
  logic [TAG_W-1:0] alloc_tag;
  logic [37:0]      head;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (issue_rs_used_i[i] && sb_q[issue_rs_i[5*i +: 5]])
        hazard = 1'b1;
    end
    if (issue_wr_fp_i && sb_q[issue_rd_i])
      hazard = 1'b1;
  end

  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!vld_q[i])
        alloc_tag = TAG_W'(i);
    end
  end

  assign tag_free   = ~&vld_q;
  assign fifo_full  = (cnt_q == CNT_W'(RES_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign head       = mem_q[rptr_q];

  assign fpu_valid_o = rst_ni & issue_valid_i & ~hazard
                     & tag_free & ~flush_i;
  assign issue_ready_o   = fpu_valid_o & fpu_ready_i;
  assign fpu_tag_o       = alloc_tag;
  assign fpu_out_ready_o = ~fifo_full;

  assign issue_fire = issue_ready_o;
  // Results for tags that are not live (e.g. after a flush) are dropped.
  assign push = fpu_out_valid_i & ~fifo_full
              & vld_q[fpu_tag_i] & ~flush_i;
  assign pop  = ~fifo_empty & wb_ready_i;

  assign wb_valid_o = ~fifo_empty;
  assign wb_rd_o    = head[37:33];
  assign wb_fp_o    = head[32];
  assign wb_data_o  = head[31:0];
  assign busy_o     = (|vld_q) | ~fifo_empty;

  always_comb begin
    vld_d  = vld_q;
    tfp_d  = tfp_q;
    trd_d  = trd_q;
    sb_d   = sb_q;
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
      if (head[32])
        sb_d[head[37:33]] = 1'b0;
    end
    if (push) begin
      vld_d[fpu_tag_i] = 1'b0;
      mem_d[wptr_q] = {trd_q[fpu_tag_i], tfp_q[fpu_tag_i], fpu_result_i};
      wptr_d = ptr_inc(wptr_q);
    end
    if (issue_fire) begin
      vld_d[alloc_tag] = 1'b1;
      trd_d[alloc_tag] = issue_rd_i;
      tfp_d[alloc_tag] = issue_wr_fp_i;
      if (issue_wr_fp_i)
        sb_d[issue_rd_i] = 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (flush_i) begin
      vld_d  = '0;
      sb_d   = '0;
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      tfp_q  <= '0;
      sb_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NUM_TAGS; i++)
        trd_q[i] <= '0;
      for (int i = 0; i < RES_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      tfp_q  <= tfp_d;
      sb_q   <= sb_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      trd_q  <= trd_d;
      mem_q  <= mem_d;
    end
  end

`ifdef FP_FLAGS_ACCUM_EN
  logic [4:0] fflags_q, fflags_d;

  // A clear and a new status in the same cycle keep the new bits.
  always_comb begin
    fflags_d = fflags_clr_i ? 5'b0 : fflags_q;
    if (push)
      fflags_d = fflags_d | fpu_status_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      fflags_q <= '0;
    else
      fflags_q <= fflags_d;
  end

  assign fflags_o = fflags_q;
`else
  logic [5:0] unused_flags;
  assign unused_flags = {fflags_clr_i, fpu_status_i};
  assign fflags_o     = '0;
`endif

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl (NUM_TAGS=4, RES_DEPTH=2).
// Flag expectations follow FP_FLAGS_ACCUM_EN when it is defined.
module tb_fp_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [14:0] issue_rs_i;
  logic [2:0]  issue_rs_used_i;
  logic [4:0]  issue_rd_i;
  logic        issue_wr_fp_i;
  logic        fpu_valid_o;
  logic        fpu_ready_i;
  logic [1:0]  fpu_tag_o;
  logic        fpu_out_valid_i;
  logic        fpu_out_ready_o;
  logic [1:0]  fpu_tag_i;
  logic [31:0] fpu_result_i;
  logic [4:0]  fpu_status_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic        wb_fp_o;
  logic [31:0] wb_data_o;
  logic        flush_i;
  logic        busy_o;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i;

  int tests = 0;
  int fails = 0;

`ifdef FP_FLAGS_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  fp_issue_ctrl #(.NUM_TAGS(4), .RES_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_rs_i(issue_rs_i), .issue_rs_used_i(issue_rs_used_i),
    .issue_rd_i(issue_rd_i), .issue_wr_fp_i(issue_wr_fp_i),
    .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i),
    .fpu_tag_o(fpu_tag_o), .fpu_out_valid_i(fpu_out_valid_i),
    .fpu_out_ready_o(fpu_out_ready_o), .fpu_tag_i(fpu_tag_i),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_fp_o(wb_fp_o), .wb_data_o(wb_data_o),
    .flush_i(flush_i), .busy_o(busy_o),
    .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    #0;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flg(input logic [4:0] f);
    return ACC ? {27'd0, f} : 32'd0;
  endfunction

  task automatic set_op(input logic [4:0] rd, input logic [2:0] used,
                        input logic [14:0] rs);
    issue_valid_i   = 1'b1;
    issue_rd_i      = rd;
    issue_wr_fp_i   = 1'b1;
    issue_rs_used_i = used;
    issue_rs_i      = rs;
  endtask

  task automatic ret(input logic [1:0] tag, input logic [31:0] d,
                     input logic [4:0] st);
    fpu_out_valid_i = 1'b1;
    fpu_tag_i       = tag;
    fpu_result_i    = d;
    fpu_status_i    = st;
  endtask

  initial begin
    rst_ni = 1'b0;
    issue_valid_i = 1'b1; issue_rs_i = '0; issue_rs_used_i = '0;
    issue_rd_i = 5'd1; issue_wr_fp_i = 1'b1;
    fpu_ready_i = 1'b1; fpu_out_valid_i = 1'b0; fpu_tag_i = '0;
    fpu_result_i = '0; fpu_status_i = '0; wb_ready_i = 1'b0;
    flush_i = 1'b0; fflags_clr_i = 1'b0;
    #3;
    chk("rst_fpu_valid", fpu_valid_o, 0);
    chk("rst_issue_ready", issue_ready_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_out_ready", fpu_out_ready_o, 1);
    chk("rst_fflags", fflags_o, 0);
    issue_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // independent issue, rd 1..4 -> tags 0..3
    for (int i = 0; i < 4; i++) begin
      set_op(5'(i + 1), 3'b000, '0);
      #1;
      chk("ind_valid", fpu_valid_o, 1);
      chk("ind_ready", issue_ready_o, 1);
      chk("ind_tag", fpu_tag_o, i);
      tick();
    end
    set_op(5'd6, 3'b000, '0);
    #1;
    chk("full_stall", issue_ready_o, 0);
    chk("busy_inflight", busy_o, 1);
    ret(2'd2, 32'hA000_0002, 5'b00001);
    #1;
    chk("freed_not_reused", issue_ready_o, 0);
    tick();
    chk("wb_n1_valid", wb_valid_o, 1);
    chk("wb_n1_rd", wb_rd_o, 3);
    chk("wb_n1_data", wb_data_o, 32'hA000_0002);
    chk("wb_n1_fp", wb_fp_o, 1);
    chk("flags_1", fflags_o, flg(5'b00001));
    chk("reuse_ready", issue_ready_o, 1);
    chk("reuse_tag", fpu_tag_o, 2);
    ret(2'd0, 32'hA000_0000, 5'b10000);
    tick();
    issue_valid_i = 1'b0;
    chk("flags_2", fflags_o, flg(5'b10001));
    ret(2'd1, 32'hA000_0001, 5'b00100);
    #1;
    chk("fifo_full_ready", fpu_out_ready_o, 0);
    tick();
    chk("fifo_full_hold", fpu_out_ready_o, 0);
    chk("head_hold_rd", wb_rd_o, 3);
    wb_ready_i = 1'b1;
    #1;
    chk("full_push_pop", fpu_out_ready_o, 0);
    tick();
    chk("after_pop_ready", fpu_out_ready_o, 1);
    chk("wb_n2_rd", wb_rd_o, 1);
    chk("wb_n2_data", wb_data_o, 32'hA000_0000);
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    fpu_out_valid_i = 1'b0;
    chk("flags_clr_set", fflags_o, flg(5'b00100));
    chk("wb_n3_rd", wb_rd_o, 2);
    chk("wb_n3_data", wb_data_o, 32'hA000_0001);
    tick();
    wb_ready_i = 1'b0;
    chk("fifo_drained", wb_valid_o, 0);

    // RAW on f4 (tag 3 still live), WAW on f6 (tag 2 live)
    set_op(5'd6, 3'b000, '0);
    #1;
    chk("waw_block", fpu_valid_o, 0);
    set_op(5'd7, 3'b001, 15'd4);
    #1;
    chk("raw_block", fpu_valid_o, 0);
    ret(2'd3, 32'hA000_0003, 5'b00000);
    tick();
    fpu_out_valid_i = 1'b0;
    wb_ready_i = 1'b1;
    #1;
    chk("raw_wb_rd", wb_rd_o, 4);
    chk("raw_no_bypass", fpu_valid_o, 0);
    tick();
    wb_ready_i = 1'b0;
    chk("raw_issue", issue_ready_o, 1);
    chk("raw_tag", fpu_tag_o, 0);
    tick();
    set_op(5'd8, 3'b000, '0);
    #1;
    chk("third_tag", fpu_tag_o, 1);
    tick();

    // flush with tags 0,1,2 in flight
    set_op(5'd9, 3'b000, '0);
    flush_i = 1'b1;
    #1;
    chk("flush_block", fpu_valid_o, 0);
    chk("flush_busy_pre", busy_o, 1);
    tick();
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 0);
    fpu_ready_i = 1'b0;
    set_op(5'd9, 3'b111, {5'd8, 5'd7, 5'd6});
    #1;
    chk("flush_sb_clear", fpu_valid_o, 1);
    chk("flush_tag0", fpu_tag_o, 0);
    chk("no_fpu_ready", issue_ready_o, 0);
    issue_valid_i = 1'b0;
    ret(2'd1, 32'hDEAD_0001, 5'b01000);
    #1;
    chk("stale_ready", fpu_out_ready_o, 1);
    tick();
    fpu_out_valid_i = 1'b0;
    chk("stale_dropped", wb_valid_o, 0);
    chk("stale_busy", busy_o, 0);
    chk("flags_kept", fflags_o, flg(5'b00100));

    // reset in the middle of operation
    fpu_ready_i = 1'b1;
    set_op(5'd10, 3'b000, '0);
    tick();
    issue_valid_i = 1'b0;
    chk("pre_rst_busy", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_flags", fflags_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("post_rst_wb", wb_valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
